wb_sram16_ctrl: RTL

//  Wishbone pipelined slave that sits directly downstream of the LSU master port.

---
 rtl/wb_sram16_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wb_sram16_ctrl.sv
// Pipelined Wishbone slave that queues halfword requests and plays them out
// on an asynchronous 16-bit SRAM with programmable wait states.
module wb_sram16_ctrl #(
    parameter int unsigned AW          = 19,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [63:0]   wbsadr_i,
    input  logic [15:0]   wbsdat_i,
    input  logic          wbswe_i,
    input  logic          wbsstb_i,
    input  logic          wbscyc_i,
    output logic          wbsstall_o,
    output logic          wbsack_o,
    output logic [15:0]   wbsdat_o,
    output logic [AW-1:0] sram_a_o,
    output logic [15:0]   sram_d_o,
    output logic          sram_doe_o,
    input  logic [15:0]   sram_d_i,
    output logic          sram_ce_n_o,
    output logic          sram_oe_n_o,
    output logic          sram_we_n_o
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t        state, state_d;
    logic [AW-1:0] q_adr [QDEPTH];
    logic          q_we  [QDEPTH];
    logic [15:0]   q_dat [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] cnt;
    logic          abort_pend, we_r;
    logic          push, pop, done, abort, we_d, ack_d;
    logic          unused_adr_bits;

    assign unused_adr_bits = ^{wbsadr_i[63:AW+1], wbsadr_i[0]};

    assign wbsstall_o = (count == CW'(QDEPTH)) | abort_pend;
    assign push       = wbscyc_i & wbsstb_i & ~wbsstall_o;
    assign abort      = ~wbscyc_i & ((count != '0) | (state != IDLE));

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && wbscyc_i && !abort_pend) begin
                    pop     = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    done    = 1'b1;
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the pads never see decode glitches.
    assign we_d  = pop ? q_we[rd_ptr] : we_r;
    assign ack_d = done & wbscyc_i & ~abort_pend;

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_adr[wr_ptr] <= wbsadr_i[AW:1];
            q_we[wr_ptr]  <= wbswe_i;
            q_dat[wr_ptr] <= wbsdat_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            cnt         <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            abort_pend  <= 1'b0;
            we_r        <= 1'b0;
            sram_a_o    <= '0;
            sram_d_o    <= '0;
            sram_doe_o  <= 1'b0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            wbsack_o    <= 1'b0;
            wbsdat_o    <= '0;
        end else begin
            state <= state_d;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            // Abort drops everything queued; the access already on the pins still finishes.
            if (abort) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            abort_pend <= (abort | abort_pend) & (state_d != IDLE);

            if (pop) begin
                sram_a_o <= q_adr[rd_ptr];
                sram_d_o <= q_dat[rd_ptr];
                we_r     <= q_we[rd_ptr];
                cnt      <= WW'(WAIT_STATES);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            sram_ce_n_o <= (state_d != ACCESS);
            sram_oe_n_o <= ~((state_d == ACCESS) & ~we_d);
            sram_we_n_o <= ~((state_d == ACCESS) & we_d);
            sram_doe_o  <= we_d & (state_d != IDLE);

            wbsack_o <= ack_d;
            if (ack_d && !we_r)
                wbsdat_o <= sram_d_i;
        end
    end

endmodule
